// File: rtl/frame_sequencer_pkg.sv
// Shared constants, state encoding and small helpers for the frame sequencer.
package frame_sequencer_pkg;

  // Width of the animation index.
  localparam int ANI_W       = 6;
  // Width of the frame counter and of the frame limit.
  localparam int FRAME_W     = 6;
  // Number of valid animations. Legal indices are 0..NUM_ANI-1.
  localparam int NUM_ANI     = 46;
  // Prescaler width and the default clocks-per-frame at speed 0.
  localparam int FS_PRE_W    = 24;
  localparam int FS_BASE_DIV = 1_000_000;

  // Frame stepping state. RUN steps on the prescaler, PAUSED steps on the step pulse.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } seq_state_e;

  // Map an out-of-range load request onto animation 0.
  function automatic logic [ANI_W-1:0] clamp_animation(input logic [ANI_W-1:0] sel);
    return (sel < ANI_W'(NUM_ANI)) ? sel : '0;
  endfunction

  // Next animation for auto-advance. The last valid animation wraps back to 0.
  function automatic logic [ANI_W-1:0] next_animation(input logic [ANI_W-1:0] ani);
    return (ani == ANI_W'(NUM_ANI - 1)) ? '0 : ani + ANI_W'(1);
  endfunction

endpackage

// File: rtl/frame_sequencer_prescaler.sv
// Frame-rate prescaler. Counts 0..max(BASE_DIV>>speed,1)-1 while running and
// raises o_adv in the clock where it wraps, so the frame register updates on
// the following edge.
module frame_prescaler #(
  parameter int               PRE_W    = 24,
  parameter logic [PRE_W-1:0] BASE_DIV = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ena,
  input  logic       i_run,
  input  logic       i_clear,
  input  logic [1:0] i_speed,
  output logic       o_adv
);

  logic [PRE_W-1:0] r_cnt;
  logic [PRE_W-1:0] w_shifted;
  logic [PRE_W-1:0] w_term;
  logic [PRE_W-1:0] w_last;

  // Terminal count from the speed select; a shift to zero clamps the period to one clock.
  assign w_shifted = BASE_DIV >> i_speed;
  assign w_term    = (w_shifted == '0) ? PRE_W'(1) : w_shifted;
  assign w_last    = w_term - PRE_W'(1);

  // The >= compare lets a speed change that shrinks the period below the
  // current count wrap on the very next cycle instead of running the full width.
  assign o_adv = i_ena && i_run && (r_cnt >= w_last);

  // Period counter: cleared on restart, held when not running or disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_ena) begin
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_run) begin
        r_cnt <= o_adv ? '0 : r_cnt + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Time base and frame stepper for the 7-segment animation engine. Drives the
// animation index to the external frame-limit table, reads the limit back
// combinationally, and steps the frame counter 0..limit at a programmable rate.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int               PRE_W    = FS_PRE_W,
  parameter logic [PRE_W-1:0] BASE_DIV = PRE_W'(FS_BASE_DIV)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic [1:0]         speed,
  input  logic [ANI_W-1:0]   ani_sel,
  input  logic               ani_load,
  input  logic               auto_mode,
  input  logic               pause,
  input  logic               step,
  input  logic [FRAME_W-1:0] limit,
  output logic [ANI_W-1:0]   animation,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_tick,
  output logic               ani_done,
  output seq_state_e         dbg_state
);

  seq_state_e         r_state;
  logic [ANI_W-1:0]   r_animation;
  logic [FRAME_W-1:0] r_frame;
  logic               r_tick;
  logic               r_done;

  logic w_adv;
  logic w_run;
  logic w_resume;
  logic w_pre_clear;
  logic w_step;
  logic w_wrap;

  // Prescaler runs only in RUN. It restarts from 0 on a load and when
  // leaving PAUSED so the first frame after resume gets a full period.
  assign w_run       = (r_state == ST_RUN);
  assign w_resume    = (r_state == ST_PAUSED) && !pause;
  assign w_pre_clear = ani_load || w_resume;

  // Step source depends on state: the time base in RUN, the step pulse in PAUSED.
  assign w_step = w_run ? w_adv : step;

  // >= rather than == so a limit that drops below the current frame still wraps.
  assign w_wrap = (r_frame >= limit);

  frame_prescaler #(
    .PRE_W    (PRE_W),
    .BASE_DIV (BASE_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .i_ena   (ena),
    .i_run   (w_run),
    .i_clear (w_pre_clear),
    .i_speed (speed),
    .o_adv   (w_adv)
  );

  // FSM plus frame/animation registers; all outputs registered, load beats a same-cycle step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_animation <= '0;
      r_frame     <= '0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
    end else if (!ena) begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;

      case (r_state)
        ST_RUN:    if (pause)  r_state <= ST_PAUSED;
        ST_PAUSED: if (!pause) r_state <= ST_RUN;
      endcase

      if (ani_load) begin
        r_animation <= clamp_animation(ani_sel);
        r_frame     <= '0;
      end else if (w_step) begin
        r_tick <= 1'b1;
        if (w_wrap) begin
          r_frame <= '0;
          r_done  <= 1'b1;
          if (auto_mode) begin
            r_animation <= next_animation(r_animation);
          end
        end else begin
          r_frame <= r_frame + FRAME_W'(1);
        end
      end
    end
  end

  assign animation  = r_animation;
  assign frame      = r_frame;
  assign frame_tick = r_tick;
  assign ani_done   = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed tables and sequences plus a random run,
// all compared against a cycle reference model built from the behaviour rules.
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               ena;
  logic [1:0]         speed;
  logic [ANI_W-1:0]   ani_sel;
  logic               ani_load;
  logic               auto_mode;
  logic               pause;
  logic               step;
  logic [FRAME_W-1:0] limit;
  logic [ANI_W-1:0]   animation;
  logic [FRAME_W-1:0] frame;
  logic               frame_tick;
  logic               ani_done;
  seq_state_e         dbg_state;

  // Second instance with BASE_DIV=1 to see the period clamp.
  logic [FRAME_W-1:0] limit1;
  logic [ANI_W-1:0]   animation1;
  logic [FRAME_W-1:0] frame1;
  logic               frame_tick1;
  logic               ani_done1;
  seq_state_e         dbg_state1;

  // Frame-limit table model driven from each DUT's animation output.
  logic [FRAME_W-1:0] lim_tab [64];
  assign limit  = lim_tab[animation];
  assign limit1 = lim_tab[animation1];

  frame_sequencer #(.PRE_W(24), .BASE_DIV(24'd8)) u_dut (
    .clk(clk), .reset(rst), .ena(ena), .speed(speed), .ani_sel(ani_sel),
    .ani_load(ani_load), .auto_mode(auto_mode), .pause(pause), .step(step),
    .limit(limit), .animation(animation), .frame(frame), .frame_tick(frame_tick),
    .ani_done(ani_done), .dbg_state(dbg_state)
  );

  frame_sequencer #(.PRE_W(24), .BASE_DIV(24'd1)) u_dut1 (
    .clk(clk), .reset(rst), .ena(ena), .speed(speed), .ani_sel(ani_sel),
    .ani_load(ani_load), .auto_mode(auto_mode), .pause(pause), .step(step),
    .limit(limit1), .animation(animation1), .frame(frame1), .frame_tick(frame_tick1),
    .ani_done(ani_done1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks clocks elapsed in the current frame period; a frame is due when
  // the clock now ending completes the period. Pause simply follows the level.
  int m_ani, m_frame, m_since, m_period, m_lim;
  bit m_tick, m_done, m_paused, m_adv, m_stepping;

  always @(posedge clk) begin
    if (rst) begin
      m_ani = 0; m_frame = 0; m_tick = 0; m_done = 0; m_since = 0; m_paused = 0;
    end else if (!ena) begin
      m_tick = 0; m_done = 0;
    end else begin
      m_period   = 8 >> speed;
      if (m_period < 1) m_period = 1;
      m_adv      = !m_paused && (m_since + 1 >= m_period);
      m_stepping = m_paused ? step : m_adv;
      m_tick = 0; m_done = 0;
      if (ani_load) begin
        m_ani   = (int'(ani_sel) < NUM_ANI) ? int'(ani_sel) : 0;
        m_frame = 0;
      end else if (m_stepping) begin
        m_lim  = int'(lim_tab[m_ani]);
        m_tick = 1;
        if (m_frame >= m_lim) begin
          m_frame = 0;
          m_done  = 1;
          if (auto_mode) m_ani = (m_ani + 1) % NUM_ANI;
        end else begin
          m_frame = m_frame + 1;
        end
      end
      if (ani_load || (m_paused && !pause)) m_since = 0;
      else if (!m_paused) m_since = m_adv ? 0 : m_since + 1;
      m_paused = pause;
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_animation", int'(animation), m_ani);
      chk("model_frame", int'(frame), m_frame);
      chk("model_tick", int'(frame_tick), int'(m_tick));
      chk("model_done", int'(ani_done), int'(m_done));
      chk("model_state", int'(dbg_state), m_paused ? int'(ST_PAUSED) : int'(ST_RUN));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input int sel);
    ani_sel  = ANI_W'(sel);
    ani_load = 1'b1;
    @(negedge clk);
    ani_load = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Counts negedges until frame_tick is seen; a timeout counts as a failure.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 200);
    if (!frame_tick) chk("tick_timeout", 0, 1);
  endtask

  // ---------------- vector tables ----------------
  typedef struct { int frame; int done; } frm_vec_t;
  typedef struct { int spd; int period; } spd_vec_t;
  typedef struct { int sel; int exp_ani; } sel_vec_t;

  frm_vec_t frm_tab [5];
  spd_vec_t spd_tab [4];
  sel_vec_t sel_tab [6];

  int n, a_hold, f_hold;

  initial begin
    frm_tab = '{'{1, 0}, '{2, 0}, '{3, 0}, '{0, 1}, '{1, 0}};
    spd_tab = '{'{0, 8}, '{1, 4}, '{2, 2}, '{3, 1}};
    sel_tab = '{'{0, 0}, '{17, 17}, '{45, 45}, '{46, 0}, '{50, 0}, '{63, 0}};

    for (int i = 0; i < 64; i++) lim_tab[i] = (i < NUM_ANI) ? FRAME_W'((i % 7) + 1) : '1;
    lim_tab[0]  = 6'd3;
    lim_tab[45] = 6'd4;

    rst = 1'b1; ena = 1'b1; speed = 2'd0; ani_sel = '0; ani_load = 1'b0;
    auto_mode = 1'b0; pause = 1'b0; step = 1'b0;

    // Reset state.
    @(posedge clk);
    chk_en = 1'b1;
    cyc(2);
    chk("rst_animation", int'(animation), 0);
    chk("rst_frame", int'(frame), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_done", int'(ani_done), 0);
    rst = 1'b0;

    // speed 0, limit 3: tick every 8 clocks, frames 1,2,3,0,1, done only on 3->0.
    for (int i = 0; i < 5; i++) begin
      wait_tick(n);
      chk("t1_period", n, 8);
      chk("t1_frame", int'(frame), frm_tab[i].frame);
      chk("t1_done", int'(ani_done), frm_tab[i].done);
    end

    // Period per speed select, measured from a prescaler restart.
    for (int i = 0; i < 4; i++) begin
      speed = 2'(spd_tab[i].spd);
      pulse_load(0);
      wait_tick(n);
      chk("t2_first_period", n, spd_tab[i].period);
      wait_tick(n);
      chk("t2_period", n, spd_tab[i].period);
    end

    // BASE_DIV=1 at speed 2 clamps to one clock per frame.
    speed = 2'd2;
    cyc(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_clamp_tick", int'(frame_tick1), 1);
    end

    // Load table including out-of-range selects.
    speed = 2'd0;
    for (int i = 0; i < 6; i++) begin
      pulse_load(sel_tab[i].sel);
      chk("sel_animation", int'(animation), sel_tab[i].exp_ani);
      chk("sel_frame", int'(frame), 0);
      chk("sel_tick", int'(frame_tick), 0);
    end

    // Auto-advance from the last animation wraps to 0.
    auto_mode = 1'b1;
    speed     = 2'd3;
    pulse_load(45);
    chk("t3_load_ani", int'(animation), 45);
    for (int f = 1; f <= 4; f++) begin
      @(negedge clk);
      chk("t3_frame", int'(frame), f);
    end
    @(negedge clk);
    chk("t3_wrap_ani", int'(animation), 0);
    chk("t3_wrap_frame", int'(frame), 0);
    chk("t3_wrap_done", int'(ani_done), 1);
    auto_mode = 1'b0;

    // Load coinciding with adv: the step is lost.
    cyc(3);
    pulse_load(10);
    chk("t4_ani", int'(animation), 10);
    chk("t4_frame", int'(frame), 0);
    chk("t4_tick", int'(frame_tick), 0);
    chk("t4_done", int'(ani_done), 0);

    // Pause freezes frame; step pulses advance it; resume restarts the period.
    speed = 2'd0;
    pulse_load(0);
    pause = 1'b1;
    cyc(2);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("t5_hold_frame", int'(frame), 0);
    end
    pulse_step();
    chk("t5_step1_tick", int'(frame_tick), 1);
    chk("t5_step1_frame", int'(frame), 1);
    cyc(2);
    pulse_step();
    chk("t5_step2_tick", int'(frame_tick), 1);
    chk("t5_step2_frame", int'(frame), 2);
    pause = 1'b0;
    // One edge to leave PAUSED, then a full 8-clock period.
    wait_tick(n);
    chk("t5_resume_period", n, 9);
    chk("t5_resume_frame", int'(frame), 3);

    // Limit drops below the current frame: next step wraps.
    lim_tab[0] = 6'd9;
    speed = 2'd3;
    pulse_load(0);
    n = 0;
    while (frame != 6'd7 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach7", int'(frame), 7);
    lim_tab[0] = 6'd1;
    @(negedge clk);
    chk("t6_drop_frame", int'(frame), 0);
    chk("t6_drop_done", int'(ani_done), 1);
    lim_tab[0] = 6'd3;

    // Reset mid-count.
    pulse_load(5);
    cyc(3);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ani", int'(animation), 0);
    chk("t6_rst_frame", int'(frame), 0);
    chk("t6_rst_tick", int'(frame_tick), 0);
    chk("t6_rst_done", int'(ani_done), 0);
    rst = 1'b0;

    // ena=0 freezes everything and drops pulses.
    pulse_load(7);
    cyc(2);
    ena = 1'b0;
    @(negedge clk);
    a_hold = int'(animation);
    f_hold = int'(frame);
    for (int i = 0; i < 20; i++) begin
      ani_sel  = ANI_W'($urandom_range(0, 63));
      ani_load = 1'($urandom_range(0, 1));
      step     = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("t6_ena_ani", int'(animation), a_hold);
      chk("t6_ena_frame", int'(frame), f_hold);
      chk("t6_ena_tick", int'(frame_tick), 0);
    end
    ani_load = 1'b0; step = 1'b0; ena = 1'b1;

    // Random run checked by the model.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 499) == 0);
      ena      = ($urandom_range(0, 9) != 0);
      ani_load = ($urandom_range(0, 39) == 0);
      ani_sel  = ANI_W'($urandom_range(0, 63));
      step     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0)  pause = !pause;
      if ($urandom_range(0, 99) == 0)  speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) auto_mode = !auto_mode;
      if ($urandom_range(0, 99) == 0)  lim_tab[$urandom_range(0, 63)] = FRAME_W'($urandom_range(0, 63));
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
